prf_operand_fetch: RTL and testbench



---
 rtl/prf_operand_fetch_pkg.sv | 20 ++
 rtl/prf_operand_fetch.sv | 124 ++++++++++++
 tb/tb_prf_operand_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/prf_operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prf_operand_fetch_pkg
// Purpose  : Shared widths and request-slot type for the operand-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package prf_operand_fetch_pkg;

  localparam int PREG_W = 6;
  localparam int XLEN   = 32;

  // Fixed-width fields of a uop waiting for a PRF read port. The payload is
  // sized per instance and is kept in a separate register.
  typedef struct packed {
    logic [PREG_W-1:0] rs1_preg;
    logic [PREG_W-1:0] rs2_preg;
  } op_fetch_req_t;

endpackage : prf_operand_fetch_pkg
`default_nettype wire

// File: rtl/prf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : prf_operand_fetch
// Purpose  : Holds one issued uop, requests a shared PRF read port, captures
//            the granted operands and presents them to the FU (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module prf_operand_fetch
  import prf_operand_fetch_pkg::*;
#(
  parameter int PAYLOAD_W    = 64,
  parameter int CNT_W        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic                 i_iss_valid,
  output logic                 o_iss_ready,
  input  logic [PREG_W-1:0]    i_iss_rs1_preg,
  input  logic [PREG_W-1:0]    i_iss_rs2_preg,
  input  logic [PAYLOAD_W-1:0] i_iss_payload,
  output logic                 o_exec_req,
  output logic [PREG_W-1:0]    o_exec_rs1_preg,
  output logic [PREG_W-1:0]    o_exec_rs2_preg,
  input  logic                 i_exec_grant,
  input  logic [XLEN-1:0]      i_exec_rs1_data,
  input  logic [XLEN-1:0]      i_exec_rs2_data,
  output logic                 o_fu_valid,
  input  logic                 i_fu_ready,
  output logic [XLEN-1:0]      o_fu_rs1_data,
  output logic [XLEN-1:0]      o_fu_rs2_data,
  output logic [PAYLOAD_W-1:0] o_fu_payload,
  output logic                 o_starve_alarm
);

  localparam logic [CNT_W-1:0] c_cnt_max      = '1;
  localparam logic [CNT_W-1:0] c_starve_limit = CNT_W'(STARVE_LIMIT);

  // Request slot
  logic                 r_req_valid;
  op_fetch_req_t        r_req;
  logic [PAYLOAD_W-1:0] r_req_payload;

  // Output slot
  logic                 r_out_valid;
  logic [XLEN-1:0]      r_out_rs1_data;
  logic [XLEN-1:0]      r_out_rs2_data;
  logic [PAYLOAD_W-1:0] r_out_payload;

  logic [CNT_W-1:0]     r_starve_cnt;

  logic w_exec_req;
  logic w_grant_fire;
  logic w_iss_fire;
  logic w_drain;

  // Only request when the output slot can take the grant this very cycle, so
  // a grant is never wasted. Must not depend on i_iss_valid (no comb loop).
  assign w_exec_req   = r_req_valid && (!r_out_valid || i_fu_ready) && !i_flush;
  assign w_grant_fire = w_exec_req && i_exec_grant;
  assign o_iss_ready  = !i_flush && (!r_req_valid || w_grant_fire);
  assign w_iss_fire   = i_iss_valid && o_iss_ready;
  assign w_drain      = r_out_valid && i_fu_ready;

  assign o_exec_req      = w_exec_req;
  assign o_exec_rs1_preg = r_req.rs1_preg;
  assign o_exec_rs2_preg = r_req.rs2_preg;
  assign o_fu_valid      = r_out_valid;
  assign o_fu_rs1_data   = r_out_rs1_data;
  assign o_fu_rs2_data   = r_out_rs2_data;
  assign o_fu_payload    = r_out_payload;
  assign o_starve_alarm  = (r_starve_cnt >= c_starve_limit);

  // Request slot: load on issue, otherwise empty once the port is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_valid   <= 1'b0;
      r_req         <= '0;
      r_req_payload <= '0;
    end else if (i_flush) begin
      r_req_valid   <= 1'b0;
    end else if (w_iss_fire) begin
      r_req_valid   <= 1'b1;
      r_req.rs1_preg <= i_iss_rs1_preg;
      r_req.rs2_preg <= i_iss_rs2_preg;
      r_req_payload <= i_iss_payload;
    end else if (w_grant_fire) begin
      r_req_valid   <= 1'b0;
    end
  end

  // Output slot: capture PRF data on grant, empty on FU consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_rs1_data <= '0;
      r_out_rs2_data <= '0;
      r_out_payload  <= '0;
    end else if (i_flush) begin
      r_out_valid    <= 1'b0;
    end else if (w_grant_fire) begin
      r_out_valid    <= 1'b1;
      r_out_rs1_data <= i_exec_rs1_data;
      r_out_rs2_data <= i_exec_rs2_data;
      r_out_payload  <= r_req_payload;
    end else if (w_drain) begin
      r_out_valid    <= 1'b0;
    end
  end

  // Starvation counter: counts denied requests; FU backpressure holds it.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_starve_cnt <= '0;
    end else if (w_grant_fire || !r_req_valid) begin
      r_starve_cnt <= '0;
    end else if (w_exec_req && (r_starve_cnt != c_cnt_max)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule : prf_operand_fetch
`default_nettype wire

// File: tb/tb_prf_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_prf_operand_fetch
// Purpose  : Scoreboard bench for prf_operand_fetch with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prf_operand_fetch;
  import prf_operand_fetch_pkg::*;

  localparam int PAYLOAD_W    = 64;
  localparam int CNT_W        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_flush, i_iss_valid, i_exec_grant, i_fu_ready;
  logic [PREG_W-1:0]    i_iss_rs1_preg, i_iss_rs2_preg;
  logic [PAYLOAD_W-1:0] i_iss_payload;
  logic [XLEN-1:0]      i_exec_rs1_data, i_exec_rs2_data;
  logic                 o_iss_ready, o_exec_req, o_fu_valid, o_starve_alarm;
  logic [PREG_W-1:0]    o_exec_rs1_preg, o_exec_rs2_preg;
  logic [XLEN-1:0]      o_fu_rs1_data, o_fu_rs2_data;
  logic [PAYLOAD_W-1:0] o_fu_payload;

  prf_operand_fetch #(
    .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_iss_valid(i_iss_valid), .o_iss_ready(o_iss_ready),
    .i_iss_rs1_preg(i_iss_rs1_preg), .i_iss_rs2_preg(i_iss_rs2_preg),
    .i_iss_payload(i_iss_payload),
    .o_exec_req(o_exec_req), .o_exec_rs1_preg(o_exec_rs1_preg),
    .o_exec_rs2_preg(o_exec_rs2_preg), .i_exec_grant(i_exec_grant),
    .i_exec_rs1_data(i_exec_rs1_data), .i_exec_rs2_data(i_exec_rs2_data),
    .o_fu_valid(o_fu_valid), .i_fu_ready(i_fu_ready),
    .o_fu_rs1_data(o_fu_rs1_data), .o_fu_rs2_data(o_fu_rs2_data),
    .o_fu_payload(o_fu_payload), .o_starve_alarm(o_starve_alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]      d1;
    logic [XLEN-1:0]      d2;
    logic [PAYLOAD_W-1:0] pay;
  } exp_t;

  typedef struct {
    logic [PREG_W-1:0]    p1;
    logic [PREG_W-1:0]    p2;
    logic [PAYLOAD_W-1:0] pay;
  } uop_t;

  // Reference model: uops waiting for a port, and count of uops held for the FU.
  uop_t pend[$];
  int   held;
  int   wait_cnt;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int alarm_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: whenever the FU consumes, the presented uop must be the oldest
  // captured one.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !i_flush && o_fu_valid && i_fu_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("fu_rs1_data", 64'(o_fu_rs1_data), 64'(e.d1));
          chk("fu_rs2_data", 64'(o_fu_rs2_data), 64'(e.d2));
          chk("fu_payload",  o_fu_payload, e.pay);
        end
      end
    end
  end

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, then advance the model by what the stage should have done.
  task automatic cyc(input bit iv, input logic [PREG_W-1:0] p1, input logic [PREG_W-1:0] p2,
                     input logic [PAYLOAD_W-1:0] pay, input bit gr,
                     input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                     input bit fr, input bit fl);
    bit port_wanted, exp_req, exp_ird, granted, issued;
    @(negedge clk);
    i_iss_valid = iv; i_iss_rs1_preg = p1; i_iss_rs2_preg = p2; i_iss_payload = pay;
    i_exec_grant = gr; i_exec_rs1_data = d1; i_exec_rs2_data = d2;
    i_fu_ready = fr; i_flush = fl;
    #1;
    port_wanted = (pend.size() > 0);
    exp_req = port_wanted && (held == 0 || fr) && !fl;
    exp_ird = !fl && (!port_wanted || (exp_req && gr));
    chk("exec_req",     64'(o_exec_req),     64'(exp_req));
    chk("iss_ready",    64'(o_iss_ready),    64'(exp_ird));
    chk("fu_valid",     64'(o_fu_valid),     64'(held > 0));
    chk("starve_alarm", 64'(o_starve_alarm), 64'(wait_cnt >= STARVE_LIMIT));
    if (o_starve_alarm) alarm_seen++;
    if (exp_req) begin
      chk("exec_rs1_preg", 64'(o_exec_rs1_preg), 64'(pend[0].p1));
      chk("exec_rs2_preg", 64'(o_exec_rs2_preg), 64'(pend[0].p2));
    end
    granted = exp_req && gr;
    issued  = iv && exp_ird;
    if (fl) begin
      pend.delete(); sb.delete(); held = 0; wait_cnt = 0;
    end else begin
      if (granted || !port_wanted) wait_cnt = 0;
      else if (exp_req && wait_cnt < CNT_MAX) wait_cnt++;
      if (granted) begin
        sb.push_back('{d1: d1, d2: d2, pay: pend[0].pay});
        void'(pend.pop_front());
        held = 1;
      end else if (held > 0 && fr) begin
        held = 0;
      end
      if (issued) pend.push_back('{p1: p1, p2: p2, pay: pay});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_flush = 1'b0; i_iss_valid = 1'b0; i_exec_grant = 1'b0; i_fu_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_fu_valid",  64'(o_fu_valid),     64'd0);
    chk("rst_exec_req",  64'(o_exec_req),     64'd0);
    chk("rst_alarm",     64'(o_starve_alarm), 64'd0);
    chk("rst_iss_ready", 64'(o_iss_ready),    64'd1);
    chk("rst_fu_rs1",    64'(o_fu_rs1_data),  64'd0);
    chk("rst_fu_rs2",    64'(o_fu_rs2_data),  64'd0);
    chk("rst_fu_pay",    o_fu_payload,        64'd0);
    rst = 1'b0;
    pend.delete(); sb.delete(); held = 0; wait_cnt = 0;
  endtask

  initial begin
    held = 0; wait_cnt = 0;
    i_iss_rs1_preg = '0; i_iss_rs2_preg = '0; i_iss_payload = '0;
    i_exec_rs1_data = '0; i_exec_rs2_data = '0;
    do_reset();

    // Single uop, minimum latency.
    cyc(1, 6'd5, 6'd9, 64'hA5, 1, 32'h11, 32'h22, 1, 0);
    cyc(0, 6'd0, 6'd0, 64'h0,  1, 32'h11, 32'h22, 1, 0);
    cyc(0, 6'd0, 6'd0, 64'h0,  1, 32'h33, 32'h44, 1, 0);

    // Back-to-back stream with grant and fu_ready always high.
    for (int i = 0; i < 6; i++)
      cyc(i < 4, 6'(i + 1), 6'(i + 20), 64'(100 + i), 1, 32'(i * 16), 32'(i * 16 + 1), 1, 0);

    // FU backpressure with both slots full.
    cyc(1, 6'd1, 6'd2, 64'hB0, 1, 32'h1, 32'h2, 0, 0);
    cyc(1, 6'd3, 6'd4, 64'hB1, 1, 32'h3, 32'h4, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(1, 6'd7, 6'd8, 64'hB2, 1, 32'h5, 32'h6, 0, 0);
    cyc(0, 6'd0, 6'd0, 64'h0, 1, 32'hAB, 32'hCD, 1, 0);
    cyc(0, 6'd0, 6'd0, 64'h0, 1, 32'h0,  32'h0,  1, 0);

    // Grant withheld long enough to raise the starvation alarm.
    cyc(1, 6'd10, 6'd11, 64'hC0, 0, 32'h0, 32'h0, 1, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 6'd0, 6'd0, 64'h0, 0, 32'h0, 32'h0, 1, 0);
    cyc(0, 6'd0, 6'd0, 64'h0, 1, 32'h77, 32'h88, 1, 0);
    cyc(0, 6'd0, 6'd0, 64'h0, 0, 32'h0,  32'h0,  1, 0);
    chk("alarm_was_seen", 64'(alarm_seen > 0), 64'd1);

    // Flush with both slots full while issue and grant are offered.
    cyc(1, 6'd1, 6'd2, 64'hD0, 1, 32'h1, 32'h2, 0, 0);
    cyc(1, 6'd3, 6'd4, 64'hD1, 1, 32'h3, 32'h4, 0, 0);
    cyc(1, 6'd5, 6'd6, 64'hD2, 1, 32'h5, 32'h6, 0, 1);
    cyc(0, 6'd0, 6'd0, 64'h0,  1, 32'h0, 32'h0, 1, 0);

    // Reset mid-stream with both slots full.
    cyc(1, 6'd1, 6'd2, 64'hE0, 1, 32'hDEAD, 32'hBEEF, 0, 0);
    cyc(1, 6'd3, 6'd4, 64'hE1, 1, 32'hFACE, 32'hCAFE, 0, 0);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
          {$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom, $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      if (i == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prf_operand_fetch
`default_nettype wire
